// File: rtl/cv3_maxpool2_if.sv
// ============================================================================
// Module      : cv3_maxpool2_if
// Description : Column-stream bundle between the conv stage, the 2x2 max-pool
//               stage and the next layer's column buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cv3_maxpool2_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int IN_COL_SIZE  = 10,
  parameter int OUT_COL_SIZE = IN_COL_SIZE / 2
);
  logic                                     valid_in;
  logic [IN_COL_SIZE-1:0][DATA_WIDTH-1:0]   input_column;
  logic [OUT_COL_SIZE-1:0][DATA_WIDTH-1:0]  output_column;
  logic                                     valid_out;
  logic                                     frame_done;

  // Producer of input columns / consumer of pooled columns
  modport master (
    output valid_in,
    output input_column,
    input  output_column,
    input  valid_out,
    input  frame_done
  );

  // The pooling stage itself
  modport slave (
    input  valid_in,
    input  input_column,
    output output_column,
    output valid_out,
    output frame_done
  );
endinterface

`default_nettype wire

// File: rtl/cv3_maxpool2.sv
// ============================================================================
// Module      : cv3_maxpool2
// Description : 2x2 stride-2 max-pool over a stream of FP16 columns with
//               optional ReLU; one pooled half-height column per input pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv3_maxpool2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int IN_COL_SIZE = 10,
  parameter int IMG_COLS    = 10,
  parameter int RELU_EN     = 1
) (
  input  wire             clk,
  input  wire             rst,
  cv3_maxpool2_if.slave   bus
);

  localparam int OUT_COL_SIZE = IN_COL_SIZE / 2;
  localparam int CNT_W        = (IMG_COLS > 2) ? $clog2(IMG_COLS) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_COLS - 1);

  typedef enum logic [0:0] {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  typedef logic [IN_COL_SIZE-1:0][DATA_WIDTH-1:0]  in_col_t;
  typedef logic [OUT_COL_SIZE-1:0][DATA_WIDTH-1:0] out_col_t;

  phase_t     phase_q, phase_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  in_col_t    hold_q, hold_d;
  out_col_t   out_q, out_d;
  logic       valid_q, valid_d;
  logic       frame_done_q, frame_done_d;
  out_col_t   pool_max;

  // Map FP16 onto a key whose unsigned order matches numeric order
  // (negatives inverted, positives lifted above them; +0 sorts above -0).
  function automatic logic [DATA_WIDTH-1:0] ord_key(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? ~x : (x | {1'b1, {(DATA_WIDTH-1){1'b0}}});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    return (ord_key(a) >= ord_key(b)) ? a : b;
  endfunction

  // Per output row: max over the 2x2 window (held column + current column), then ReLU
  for (genvar k = 0; k < OUT_COL_SIZE; k++) begin : g_pool
    logic [DATA_WIDTH-1:0] max_hold;
    logic [DATA_WIDTH-1:0] max_in;
    logic [DATA_WIDTH-1:0] max_all;

    assign max_hold = fp_max(hold_q[2*k], hold_q[2*k+1]);
    assign max_in   = fp_max(bus.input_column[2*k], bus.input_column[2*k+1]);
    assign max_all  = fp_max(max_hold, max_in);
    // A set sign bit (including -0) is clamped to +0 when ReLU is enabled
    assign pool_max[k] = ((RELU_EN != 0) && max_all[DATA_WIDTH-1]) ? '0 : max_all;
  end

  // Next-state: phase toggles per column, column counter wraps at frame end
  always_comb begin
    phase_d      = phase_q;
    col_cnt_d    = col_cnt_q;
    hold_d       = hold_q;
    out_d        = out_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;

    if (bus.valid_in) begin
      case (phase_q)
        EVEN: begin
          hold_d  = bus.input_column;
          phase_d = ODD;
        end
        ODD: begin
          out_d   = pool_max;
          valid_d = 1'b1;
          phase_d = EVEN;
        end
        default: phase_d = EVEN;
      endcase

      if (col_cnt_q == LAST_COL) begin
        col_cnt_d    = '0;
        // Re-align pairing at every frame boundary
        phase_d      = EVEN;
        frame_done_d = (phase_q == ODD);
      end else begin
        col_cnt_d = col_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers; reset discards any half-collected pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= EVEN;
      col_cnt_q    <= '0;
      hold_q       <= '0;
      out_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      col_cnt_q    <= col_cnt_d;
      hold_q       <= hold_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.output_column = out_q;
  assign bus.valid_out     = valid_q;
  assign bus.frame_done    = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_cv3_maxpool2.sv
// ============================================================================
// Module      : tb_cv3_maxpool2
// Description : Scoreboard bench for cv3_maxpool2; two instances (ReLU on and
//               off) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv3_maxpool2;

  localparam int DW   = 16;
  localparam int IN   = 10;
  localparam int OUT  = IN / 2;
  localparam int IMG  = 10;

  typedef logic [IN-1:0][DW-1:0]  col_t;
  typedef logic [OUT-1:0][DW-1:0] out_t;

  typedef struct {
    out_t out;
    logic fd;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q_r[$];
  exp_t q_n[$];

  // reference model state (stimulus bookkeeping)
  int   m_phase = 0;
  int   m_cnt   = 0;
  col_t m_hold;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  cv3_maxpool2_if #(.DATA_WIDTH(DW), .IN_COL_SIZE(IN)) if_r ();
  cv3_maxpool2_if #(.DATA_WIDTH(DW), .IN_COL_SIZE(IN)) if_n ();

  cv3_maxpool2 #(.DATA_WIDTH(DW), .IN_COL_SIZE(IN), .IMG_COLS(IMG), .RELU_EN(1)) dut_r (
    .clk (clk),
    .rst (rst),
    .bus (if_r.slave)
  );

  cv3_maxpool2 #(.DATA_WIDTH(DW), .IN_COL_SIZE(IN), .IMG_COLS(IMG), .RELU_EN(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (if_n.slave)
  );

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] key(input logic [DW-1:0] x);
    return x[DW-1] ? ~x : (x | 16'h8000);
  endfunction

  function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (key(a) > key(b)) ? a : b;
  endfunction

  function automatic out_t pool(input col_t h, input col_t c, input bit relu);
    out_t r;
    for (int k = 0; k < OUT; k++) begin
      logic [DW-1:0] m;
      m = mx(mx(h[2*k], h[2*k+1]), mx(c[2*k], c[2*k+1]));
      r[k] = (relu && m[DW-1]) ? 16'h0000 : m;
    end
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mon(input int inst, input logic v, input out_t o, input logic fd);
    exp_t e;
    if (v) begin
      checks++;
      if ((inst == 0 && q_r.size() == 0) || (inst == 1 && q_n.size() == 0)) begin
        errors++;
        $display("FAIL mon%0d unexpected valid_out at cycle %0d out=%h", inst, cyc_cnt, o);
      end else begin
        e = (inst == 0) ? q_r.pop_front() : q_n.pop_front();
        if (o !== e.out || fd !== e.fd || cyc_cnt != e.cyc) begin
          errors++;
          $display("FAIL mon%0d pooled column: actual out=%h fd=%b cyc=%0d required out=%h fd=%b cyc=%0d",
                   inst, o, fd, cyc_cnt, e.out, e.fd, e.cyc);
        end
      end
    end else if (fd) begin
      checks++;
      errors++;
      $display("FAIL mon%0d frame_done without valid_out at cycle %0d", inst, cyc_cnt);
    end
  endtask

  // Monitor: compares every presented output against the scoreboard
  always @(negedge clk) begin
    mon(0, if_r.valid_out, if_r.output_column, if_r.frame_done);
    mon(1, if_n.valid_out, if_n.output_column, if_n.frame_done);
  end

  // ---------------- stimulus helpers ----------------
  // Entered and left #1 after a rising edge; inputs stay asserted on return.
  task automatic send_col(input col_t c);
    exp_t e;
    if_r.valid_in = 1'b1;  if_r.input_column = c;
    if_n.valid_in = 1'b1;  if_n.input_column = c;
    if (m_phase == 0) begin
      m_hold  = c;
      m_phase = 1;
    end else begin
      e.fd  = (m_cnt == IMG - 1);
      e.cyc = cyc_cnt + 1;
      e.out = pool(m_hold, c, 1'b1);  q_r.push_back(e);
      e.out = pool(m_hold, c, 1'b0);  q_n.push_back(e);
      m_phase = 0;
    end
    if (m_cnt == IMG - 1) begin
      m_cnt   = 0;
      m_phase = 0;
    end else begin
      m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    if_r.valid_in = 1'b0;
    if_n.valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic col_t rand_col();
    col_t c;
    logic [DW-1:0] sp [10];
    sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h0001,
           16'h8001, 16'h03FF, 16'h83FF, 16'h7BFF, 16'hFBFF};
    for (int r = 0; r < IN; r++)
      c[r] = ($urandom_range(0, 1) == 1) ? sp[$urandom_range(0, 9)] : DW'($urandom);
    return c;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    col_t a, b;
    if_r.valid_in = 1'b0;  if_r.input_column = '0;
    if_n.valid_in = 1'b0;  if_n.input_column = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_r", 80'(if_r.output_column), 80'h0);
    chk("reset valid_r", 80'(if_r.valid_out), 80'h0);
    chk("reset fd_r", 80'(if_r.frame_done), 80'h0);
    chk("reset out_n", 80'(if_n.output_column), 80'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Test 1: basic max, consecutive columns
    a = '0; a[0] = 16'h3C00; a[1] = 16'h4000; a[2] = 16'h4200; a[3] = 16'h4400;
    b = '0; b[0] = 16'h3800; b[1] = 16'hBC00; b[2] = 16'h4500; b[3] = 16'hC500;
    send_col(a);
    chk("t1 no valid after col0", 80'(if_r.valid_out), 80'h0);
    send_col(b);
    idle(0);
    chk("t1 out0", 80'(if_r.output_column[0]), 80'h4000);
    chk("t1 out1", 80'(if_r.output_column[1]), 80'h4500);
    chk("t1 valid", 80'(if_r.valid_out), 80'h1);
    idle(1);
    chk("t1 valid drops", 80'(if_r.valid_out), 80'h0);

    // Test 2: all-negative window with -0 as max
    a = '0; a[0] = 16'hBC00; a[1] = 16'hC000;
    b = '0; b[0] = 16'hBC00; b[1] = 16'h8000;
    send_col(a);
    send_col(b);
    idle(0);
    chk("t2 relu out0", 80'(if_r.output_column[0]), 80'h0000);
    chk("t2 norelu out0", 80'(if_n.output_column[0]), 80'h8000);
    idle(1);

    // Test 3: gapped pair
    a = '0; a[0] = 16'h5000; a[1] = 16'h4800;
    b = '0; b[0] = 16'h0001; b[1] = 16'hFBFF;
    send_col(a);
    idle(5);
    chk("t3 hold before n", 80'(if_n.output_column[0]), 80'h8000);
    chk("t3 hold before r", 80'(if_r.output_column), 80'h0);
    send_col(b);
    idle(0);
    chk("t3 out0", 80'(if_r.output_column[0]), 80'h5000);
    idle(3);
    chk("t3 stable after", 80'(if_r.output_column[0]), 80'h5000);
    chk("t3 valid low after", 80'(if_r.valid_out), 80'h0);

    // Fill out the first frame (columns 6..9); frame_done on column 9
    for (int i = 0; i < 4; i++) send_col(rand_col());
    idle(0);
    chk("frame1 done", 80'(if_r.frame_done), 80'h1);

    // Test 4: full frame back-to-back, then the 11th column starts a new pair
    for (int i = 0; i < IMG; i++) send_col(rand_col());
    idle(0);
    chk("t4 frame done", 80'(if_n.frame_done), 80'h1);
    send_col(rand_col());
    idle(0);
    chk("t4 11th no valid", 80'(if_r.valid_out), 80'h0);

    // Test 5: reset mid-pair (11th column is held); valid_in during reset ignored
    rst = 1'b1;
    if_r.valid_in = 1'b1;  if_r.input_column = rand_col();
    if_n.valid_in = 1'b1;  if_n.input_column = if_r.input_column;
    #1;
    chk("t5 reset out", 80'(if_n.output_column), 80'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_phase = 0;
    m_cnt   = 0;
    idle(1);
    for (int i = 0; i < IMG; i++) send_col(rand_col());
    idle(0);
    chk("t5 frame done", 80'(if_r.frame_done), 80'h1);
    idle(2);

    // Test 6: three frames of full-range values with random gaps
    for (int i = 0; i < 3 * IMG; i++) begin
      send_col(rand_col());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    chk("scoreboard r drained", 80'(q_r.size()), 80'h0);
    chk("scoreboard n drained", 80'(q_n.size()), 80'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/cv3_maxpool2.md
Name: cv3_maxpool2

Overview:
- Downstream stage of the 3x3 convolution filter. Consumes its stream of FP16 output columns (PARALLEL_UNITS rows, one column per valid pulse) and performs 2x2 max-pooling, stride 2.
- Optional ReLU is applied after pooling.
- Emits one pooled column of half height for every two input columns, plus an end-of-frame pulse, to the next layer's column buffer.

Parameters:
- DATA_WIDTH, 16, element width; FP16 only.
- IN_COL_SIZE, 10, rows per input column (= conv PARALLEL_UNITS); must be even.
- IMG_COLS, 10, input columns per frame (conv output width); must be even and >= 2.
- RELU_EN, 1, 1 = clamp negative results to +0 after pooling.
- OUT_COL_SIZE, IN_COL_SIZE/2, localparam, rows per output column.

Ports:
- clk, input, 1, clock (rising edge).
- rst, input, 1, asynchronous active-high reset.
- valid_in, input, 1, input_column is valid this cycle; single-cycle pulses, arbitrary gaps.
- input_column, input, [DATA_WIDTH-1:0] x IN_COL_SIZE, conv output column.
- output_column, output, [DATA_WIDTH-1:0] x OUT_COL_SIZE, pooled column.
- valid_out, output, 1, output_column valid; one-cycle pulse.
- frame_done, output, 1, one-cycle pulse coincident with the valid_out of the last pooled column of a frame.

Behaviour:
- Reset (async, active-high): output_column all 0x0000, valid_out 0, frame_done 0, phase = EVEN, col_cnt = 0, held column cleared. Reset mid-pair discards the held column; the next valid_in is treated as column 0 of a new frame.
- State machine (phase), advancing only on valid_in:
  - EVEN: latch input_column into the hold register; go to ODD. No output.
  - ODD: compute the pooled column from hold + input_column; register it; go to EVEN.
- Pooling: out[k] = max(hold[2k], hold[2k+1], in[2k], in[2k+1]) for k = 0..OUT_COL_SIZE-1.
- FP16 compare:
  - Map each value to an ordered key: sign=1 -> key = ~x; sign=0 -> key = x | 0x8000. Unsigned compare of keys.
  - Consequences: +0 > -0; +NaN above all; -NaN below all; no special NaN handling.
  - Equal keys imply identical bits, so tie order is irrelevant.
- ReLU (RELU_EN=1): if the max result has sign bit 1 (including -0), output 0x0000; otherwise pass through. RELU_EN=0: pass through.
- Latency: valid_in in ODD phase at edge N -> output_column and valid_out valid after edge N+1 (one register stage). valid_out deasserts the following cycle unless another ODD column arrives; back-to-back valid_in yields valid_out every second cycle.
- output_column holds its last value between pulses.
- Column counter col_cnt (0..IMG_COLS-1):
  - Increments on every valid_in; wraps to 0 after IMG_COLS-1.
  - On the valid_in where col_cnt == IMG_COLS-1, frame_done asserts together with that column's valid_out.
  - Phase is forced to EVEN on wrap.
- valid_in while in reset: ignored.
- No backpressure. The downstream stage must accept every valid_out; no stall input exists.

Test Plan:
1. Basic max: col0 = {0x3C00, 0x4000, …}, col1 = {0x3800, 0xBC00, …}, consecutive cycles -> one cycle after col1, valid_out=1 and out[0]=0x4000 (2.0). Only one valid_out per pair.
2. Signed compare + ReLU: all four inputs of a 2x2 window = {0xBC00, 0xC000, 0xBC00, 0x8000} -> RELU_EN=1: out=0x0000; RELU_EN=0: out=0x8000 (-0 is max).
3. Gapped input: col0, 5 idle cycles, col1 -> single valid_out exactly one cycle after col1; output_column stable before and after.
4. Frame wrap: 10 back-to-back columns (IMG_COLS=10) -> 5 valid_out pulses on every second cycle; frame_done only with the 5th; the 11th column is treated as EVEN (no output).
5. Reset mid-pair: col0 loaded, rst pulsed, then colA, colB -> output equals pool(colA, colB); col0 is not used; frame_done on the 10th post-reset column.
6. Full-range pattern: random FP16 inputs including ±0, ±Inf, subnormals, over 3 frames -> bit-exact match to a reference model using the key ordering.
